leading_zero_detector: RTL and testbench

Registered leading-zero counter for the 24-bit mantissa datapath of the single-precision floating-point adder. It sits in the normalization stage after mantissa add/subtract. It reports how many zero bits precede the most-significant 1 of the sum, flags an all-zero sum, and supplies the left-normalized mantissa, all one clock after sampling.

---
 rtl/leading_zero_detector.sv | 68 ++++++
 tb/tb_leading_zero_detector.sv | 135 +++++++++++++
 2 files changed

// File: rtl/leading_zero_detector.sv
// Registered leading-zero counter for the 24-bit adder normalization stage:
// reports leading zeros, an all-zero flag and the MSB-aligned mantissa one clock after sampling.
module leading_zero_detector (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] num,
    input  logic        enable,
    output logic [4:0]  count,
    output logic        zero,
    output logic [23:0] norm,
    output logic        valid
);

    localparam int DATA_W = 24;
    localparam int CNT_W  = 5;

    // Priority encoder: ascending scan so the highest set bit wins; all-zero yields DATA_W.
    function automatic logic [CNT_W-1:0] lzc(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = CNT_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (v[i]) c = CNT_W'(DATA_W - 1 - i);
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] normalize(input logic [DATA_W-1:0] v,
                                                    input logic [CNT_W-1:0]  c);
        return v << c;
    endfunction

    // ---- stage p0: combinational encode and shift of the sampled input ----
    logic [CNT_W-1:0]  cnt_p0;
    logic              zero_p0;
    logic [DATA_W-1:0] norm_p0;

    always_comb begin
        cnt_p0  = lzc(num);
        zero_p0 = (num == '0);
        norm_p0 = normalize(num, cnt_p0);
    end

    // ---- stage p1: output registers; an idle or reset cycle presents "no shift" ----
    logic [CNT_W-1:0]  cnt_p1;
    logic              zero_p1;
    logic [DATA_W-1:0] norm_p1;
    logic              vld_p1;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt_p1  <= '0;
            zero_p1 <= 1'b0;
            norm_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            cnt_p1  <= cnt_p0;
            zero_p1 <= zero_p0;
            norm_p1 <= norm_p0;
            vld_p1  <= 1'b1;
        end
    end

    assign count = cnt_p1;
    assign zero  = zero_p1;
    assign norm  = norm_p1;
    assign valid = vld_p1;

endmodule

// File: tb/tb_leading_zero_detector.sv
// Directed and random checks of leading_zero_detector against hand values and a shift-based model.
module tb_leading_zero_detector;

    logic        clk;
    logic        rst;
    logic [23:0] num;
    logic        enable;
    logic [4:0]  count;
    logic        zero;
    logic [23:0] norm;
    logic        valid;

    int total = 0;
    int bad   = 0;

    leading_zero_detector dut (
        .clk    (clk),
        .rst    (rst),
        .num    (num),
        .enable (enable),
        .count  (count),
        .zero   (zero),
        .norm   (norm),
        .valid  (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after a falling edge; the next falling edge sees the registered result.
    task automatic step(input logic r, input logic en, input logic [23:0] n);
        rst    = r;
        enable = en;
        num    = n;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [4:0] c, input logic z,
                              input logic [23:0] nm, input logic v);
        chk({tag, ".count"}, {19'd0, count}, {19'd0, c});
        chk({tag, ".zero"},  {23'd0, zero},  {23'd0, z});
        chk({tag, ".norm"},  norm, nm);
        chk({tag, ".valid"}, {23'd0, valid}, {23'd0, v});
    endtask

    // Model: shift left one place at a time until the MSB is set.
    task automatic model(input logic [23:0] v, output logic [4:0] c, output logic z,
                         output logic [23:0] nm);
        logic [23:0] t;
        t = v;
        c = 5'd0;
        z = (v == 24'h0);
        if (z) begin
            c  = 5'd24;
            nm = 24'h0;
        end else begin
            while (!t[23]) begin
                t = t << 1;
                c = c + 5'd1;
            end
            nm = t;
        end
    endtask

    initial begin
        logic [4:0]  mc;
        logic        mz;
        logic [23:0] mn;
        logic [23:0] rv;

        rst = 1'b1; enable = 1'b1; num = 24'h000080;
        @(negedge clk);
        expect_out("reset1", 5'd0, 1'b0, 24'h0, 1'b0);
        step(1'b1, 1'b1, 24'h000080);
        expect_out("reset2", 5'd0, 1'b0, 24'h0, 1'b0);

        step(1'b0, 1'b0, 24'h000080);
        expect_out("disabled", 5'd0, 1'b0, 24'h0, 1'b0);
        step(1'b0, 1'b1, 24'h000080);
        expect_out("enabled80", 5'd16, 1'b0, 24'h800000, 1'b1);

        step(1'b0, 1'b1, 24'h100123);
        expect_out("b2b_a", 5'd3, 1'b0, 24'h800918, 1'b1);
        step(1'b0, 1'b1, 24'h009008);
        expect_out("b2b_b", 5'd8, 1'b0, 24'h900800, 1'b1);

        step(1'b0, 1'b1, 24'h000000);
        expect_out("zero_in", 5'd24, 1'b1, 24'h0, 1'b1);

        step(1'b0, 1'b1, 24'h800000);
        expect_out("msb", 5'd0, 1'b0, 24'h800000, 1'b1);
        step(1'b0, 1'b1, 24'h000001);
        expect_out("lsb", 5'd23, 1'b0, 24'h800000, 1'b1);
        step(1'b0, 1'b1, 24'hFFFFFF);
        expect_out("ones", 5'd0, 1'b0, 24'hFFFFFF, 1'b1);

        // Mid-stream reset discards the sampled value; release resumes one cycle later.
        step(1'b1, 1'b1, 24'h000010);
        expect_out("midrst", 5'd0, 1'b0, 24'h0, 1'b0);
        step(1'b0, 1'b1, 24'h000300);
        expect_out("postrst", 5'd14, 1'b0, 24'hC00000, 1'b1);

        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b1, 24'h000001 << k);
            expect_out($sformatf("walk%0d", k), 5'(23 - k), 1'b0, 24'h800000, 1'b1);
        end

        for (int i = 0; i < 1000; i++) begin
            rv = 24'($urandom()) >> $urandom_range(0, 24);
            if ((i % 50) == 7) begin
                step(1'b0, 1'b0, rv);
                expect_out("rand_idle", 5'd0, 1'b0, 24'h0, 1'b0);
            end else begin
                model(rv, mc, mz, mn);
                step(1'b0, 1'b1, rv);
                expect_out($sformatf("rand%0d_%06h", i, rv), mc, mz, mn, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
